// File: rtl/led_pattern_gen_pkg.sv
// Shared definitions for the LED pattern generator: pattern mode codes and
// the per-mode sequence length used to detect the end of a pattern.
package led_pattern_pkg;

    localparam logic [1:0] MODE_BOUNCE = 2'd0;
    localparam logic [1:0] MODE_ROTATE = 2'd1;
    localparam logic [1:0] MODE_BINARY = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    // Wide enough for 2^16, the longest sequence (binary mode at 16 LEDs).
    localparam int SEQ_LEN_W = 17;

    function automatic logic [SEQ_LEN_W-1:0] seq_len(input logic [1:0] mode,
                                                     input int unsigned n);
        logic [SEQ_LEN_W-1:0] len;
        len = SEQ_LEN_W'(2);
        case (mode)
            MODE_BOUNCE: len = SEQ_LEN_W'(2 * n - 2);
            MODE_ROTATE: len = SEQ_LEN_W'(n);
            MODE_BINARY: len = SEQ_LEN_W'(1) << n;
            default:     len = SEQ_LEN_W'(2);
        endcase
        return len;
    endfunction

endpackage

// File: rtl/led_pattern_gen_prescaler.sv
// Power-of-two selectable prescaler: fires one tick every 2^(DIV_W-SPEED)
// cycles, can be frozen with PAUSE and restarted with CLR.
module led_prescaler #(
    parameter int DIV_W = 23
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] SPEED,
    input  logic       PAUSE,
    input  logic       CLR,
    output logic       tick
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_thresh;

    assign w_thresh = {DIV_W{1'b1}} >> SPEED;

    // >= rather than == so a switch to a faster rate never waits for a wrap.
    assign tick = (r_cnt >= w_thresh) && !PAUSE && !CLR;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_cnt <= '0;
        end else if (CLR || tick) begin
            r_cnt <= '0;
        end else if (!PAUSE) begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: bounce, rotate, binary count or all-blink stepped by
// a prescaler, with registered LED drive and TICK/WRAP step strobes.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int N_LED = 4,
    parameter int DIV_W = 23
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       MODE,
    input  logic [1:0]       SPEED,
    input  logic             PAUSE,
    output logic [N_LED-1:0] LED,
    output logic             TICK,
    output logic             WRAP
);

    localparam logic [N_LED-1:0] LP_N_LED  = N_LED'(N_LED);
    localparam logic [N_LED-1:0] LP_MIRROR = N_LED'(2 * N_LED - 2);
    localparam logic [N_LED-1:0] LP_ONE    = N_LED'(1);

    logic [1:0]           r_mode_q;
    logic [N_LED-1:0]     r_step;
    logic [N_LED-1:0]     r_led;
    logic                 r_tick;
    logic                 r_wrap;

    logic                 w_mode_chg;
    logic                 w_tick;
    logic                 w_last;
    logic [SEQ_LEN_W-1:0] w_len;

    function automatic logic [N_LED-1:0] decode(input logic [1:0]       mode,
                                                input logic [N_LED-1:0] step);
        logic [N_LED-1:0] pat;
        pat = '0;
        case (mode)
            MODE_BOUNCE: begin
                if (step < LP_N_LED) pat = LP_ONE << step;
                else                 pat = LP_ONE << (LP_MIRROR - step);
            end
            MODE_ROTATE: pat = LP_ONE << step;
            MODE_BINARY: pat = step;
            default:     pat = (step != '0) ? '1 : '0;
        endcase
        return pat;
    endfunction

    assign w_mode_chg = (MODE != r_mode_q);
    assign w_len      = seq_len(r_mode_q, N_LED);
    assign w_last     = (SEQ_LEN_W'(r_step) == (w_len - SEQ_LEN_W'(1)));

    // A mode change clears the prescaler so the new pattern starts a full period.
    led_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .CLK   (CLK),
        .RST   (RST),
        .SPEED (SPEED),
        .PAUSE (PAUSE),
        .CLR   (w_mode_chg),
        .tick  (w_tick)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_mode_q <= MODE_BOUNCE;
            r_step   <= '0;
            r_led    <= '0;
            r_tick   <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_mode_q <= MODE;
            if (w_mode_chg) begin
                r_step <= '0;
            end else if (w_tick) begin
                r_step <= w_last ? '0 : r_step + LP_ONE;
            end
            r_led  <= decode(r_mode_q, r_step);
            r_tick <= w_tick;
            r_wrap <= w_tick && w_last;
        end
    end

    assign LED  = r_led;
    assign TICK = r_tick;
    assign WRAP = r_wrap;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen at N_LED=4, DIV_W=4: table-driven step
// vectors for bounce and binary, hand sequences for the timing corner cases.
module tb_led_pattern_gen;
    import led_pattern_pkg::*;

    localparam int N_LED = 4;
    localparam int DIV_W = 4;

    logic             CLK   = 1'b0;
    logic             RST   = 1'b0;
    logic [1:0]       MODE  = 2'd0;
    logic [1:0]       SPEED = 2'd0;
    logic             PAUSE = 1'b0;
    logic [N_LED-1:0] LED;
    logic             TICK;
    logic             WRAP;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int last   = 0;

    always #5 CLK = ~CLK;

    led_pattern_gen #(
        .N_LED (N_LED),
        .DIV_W (DIV_W)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .MODE  (MODE),
        .SPEED (SPEED),
        .PAUSE (PAUSE),
        .LED   (LED),
        .TICK  (TICK),
        .WRAP  (WRAP)
    );

    typedef struct {
        logic [1:0] mode;
        logic [1:0] speed;
        int         period;
        logic       wrap;
        logic [3:0] led;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // Clock until TICK is seen (bounded); report cycles since 'last', or -1.
    task automatic wait_tick(input int max, output int period);
        int n;
        n = 0;
        do begin
            tick_clk();
            n++;
        end while (!TICK && n < max);
        if (TICK) period = cyc - last;
        else      period = -1;
        last = cyc;
    endtask

    task automatic run_row(input int i);
        int p;
        MODE  = vecs[i].mode;
        SPEED = vecs[i].speed;
        wait_tick(40, p);
        chk($sformatf("row%0d_period", i), p, vecs[i].period);
        chk($sformatf("row%0d_wrap", i), int'(WRAP), int'(vecs[i].wrap));
        tick_clk();
        chk($sformatf("row%0d_led", i), int'(LED), int'(vecs[i].led));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int bad;

        vecs[0] = '{MODE_BOUNCE, 2'd0, 16, 1'b0, 4'b0010};
        vecs[1] = '{MODE_BOUNCE, 2'd0, 16, 1'b0, 4'b0100};
        vecs[2] = '{MODE_BOUNCE, 2'd0, 16, 1'b0, 4'b1000};
        vecs[3] = '{MODE_BOUNCE, 2'd0, 16, 1'b0, 4'b0100};
        vecs[4] = '{MODE_BOUNCE, 2'd0, 16, 1'b0, 4'b0010};
        vecs[5] = '{MODE_BOUNCE, 2'd0, 16, 1'b1, 4'b0001};
        for (int k = 0; k < 16; k++) begin
            vecs[6 + k] = '{MODE_BINARY, 2'd2, 4, (k == 15), 4'((k + 1) % 16)};
        end

        // Reset state
        repeat (3) tick_clk();
        chk("rst_led", int'(LED), 0);
        chk("rst_tick", int'(TICK), 0);
        chk("rst_wrap", int'(WRAP), 0);
        RST  = 1'b1;
        last = cyc;
        tick_clk();
        chk("rel_led", int'(LED), 1);
        chk("rel_tick", int'(TICK), 0);

        // Bounce at slowest rate
        for (int i = 0; i < 6; i++) run_row(i);

        // Switch to binary count, SPEED=2
        MODE  = MODE_BINARY;
        SPEED = 2'd2;
        tick_clk();
        chk("t2_sw_tick", int'(TICK), 0);
        chk("t2_sw_led", int'(LED), 4'b0001);
        last = cyc;
        tick_clk();
        chk("t2_first_led", int'(LED), 0);
        for (int i = 6; i < 22; i++) run_row(i);

        // Speed-up with counter above the new threshold
        MODE  = MODE_ROTATE;
        SPEED = 2'd0;
        tick_clk();
        chk("t3_clr_tick", int'(TICK), 0);
        bad = 0;
        repeat (10) begin
            tick_clk();
            if (TICK) bad++;
        end
        chk("t3_no_early_tick", bad, 0);
        SPEED = 2'd3;
        tick_clk();
        chk("t3_fast_next", int'(TICK), 1);
        tick_clk();
        chk("t3_gap", int'(TICK), 0);
        chk("t3_led_step1", int'(LED), 4'b0010);
        tick_clk();
        chk("t3_tick_2cyc", int'(TICK), 1);
        tick_clk();
        chk("t3_gap2", int'(TICK), 0);
        chk("t3_led_step2", int'(LED), 4'b0100);

        // Mode switch rotate -> blink while a tick would otherwise fire
        MODE = MODE_BLINK;
        tick_clk();
        chk("t4_sw_no_tick", int'(TICK), 0);
        chk("t4_sw_no_wrap", int'(WRAP), 0);
        chk("t4_sw_led_held", int'(LED), 4'b0100);
        SPEED = 2'd0;
        last  = cyc;
        tick_clk();
        chk("t4_blink_off", int'(LED), 0);
        wait_tick(40, p);
        chk("t4_period", p, 16);
        chk("t4_wrap", int'(WRAP), 0);
        tick_clk();
        chk("t4_blink_on", int'(LED), 4'b1111);

        // Pause at cnt=7 for 50 cycles
        repeat (6) tick_clk();
        PAUSE = 1'b1;
        bad   = 0;
        repeat (50) begin
            tick_clk();
            if (TICK || WRAP || LED != 4'b1111) bad++;
        end
        chk("t5_frozen", bad, 0);
        PAUSE = 1'b0;
        last  = cyc;
        wait_tick(40, p);
        chk("t5_resume_period", p, 9);
        chk("t5_wrap", int'(WRAP), 1);
        tick_clk();
        chk("t5_led", int'(LED), 0);

        // Reset mid-sequence in bounce
        MODE  = MODE_BOUNCE;
        SPEED = 2'd3;
        tick_clk();
        chk("t6_sw_no_tick", int'(TICK), 0);
        tick_clk();
        chk("t6_led_start", int'(LED), 4'b0001);
        repeat (6) tick_clk();
        chk("t6_led_top", int'(LED), 4'b1000);
        chk("t6_pre_tick", int'(TICK), 0);
        RST = 1'b0;
        tick_clk();
        chk("t6_rst_led", int'(LED), 0);
        chk("t6_rst_tick", int'(TICK), 0);
        chk("t6_rst_wrap", int'(WRAP), 0);
        RST  = 1'b1;
        last = cyc;
        tick_clk();
        chk("t6_rel_led", int'(LED), 4'b0001);
        chk("t6_rel_tick", int'(TICK), 0);
        wait_tick(40, p);
        chk("t6_period", p, 2);
        chk("t6_wrap", int'(WRAP), 0);
        tick_clk();
        chk("t6_led_step1", int'(LED), 4'b0010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
